// File: rtl/adder_sum_acc.sv
// adder_sum_acc: accumulates C_ACC_LEN unsigned sums from the adder into one
// saturating frame result, presented on a valid/ready handshake together
// with a sticky per-frame overflow flag.
module adder_sum_acc #(
    parameter int C_DATA_WIDTH = 4,
    parameter int C_ACC_LEN    = 4,
    parameter int C_ACC_WIDTH  = 8,
    parameter int C_CNT_WIDTH  = 8
) (
    input  logic                    I_sys_clk,
    input  logic                    I_rst,
    input  logic [C_DATA_WIDTH:0]   I_sum,
    input  logic                    I_sum_valid,
    output logic                    O_sum_ready,
    input  logic                    I_clr,
    output logic [C_ACC_WIDTH-1:0]  O_acc,
    output logic                    O_acc_valid,
    input  logic                    I_acc_ready,
    output logic                    O_ovf,
    output logic [C_CNT_WIDTH-1:0]  O_cnt
);

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_t;

    state_t                  state, state_nxt;
    logic [C_ACC_WIDTH-1:0]  acc, acc_nxt;
    logic                    ovf, ovf_nxt;
    logic [C_CNT_WIDTH-1:0]  cnt, cnt_nxt;

    logic                    accept;
    logic                    last;
    logic [C_ACC_WIDTH:0]    sum_ext;
    logic [C_ACC_WIDTH:0]    sum_full;

    assign accept   = I_sum_valid && (state == S_ACC);
    assign last     = (cnt == C_CNT_WIDTH'(C_ACC_LEN - 1));
    assign sum_ext  = {{(C_ACC_WIDTH - C_DATA_WIDTH){1'b0}}, I_sum};
    assign sum_full = {1'b0, acc} + sum_ext;

    // Next-state and datapath update; clear overrides every other action.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        cnt_nxt   = cnt;
        if (I_clr) begin
            state_nxt = S_ACC;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        // carry out of the extended add means the frame saturated
                        if (sum_full[C_ACC_WIDTH]) begin
                            acc_nxt = '1;
                            ovf_nxt = 1'b1;
                        end else begin
                            acc_nxt = sum_full[C_ACC_WIDTH-1:0];
                        end
                        if (last) begin
                            cnt_nxt   = '0;
                            state_nxt = S_OUT;
                        end else begin
                            cnt_nxt = cnt + C_CNT_WIDTH'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (I_acc_ready) begin
                        state_nxt = S_ACC;
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: state_nxt = S_ACC;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state <= S_ACC;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign O_sum_ready = (state == S_ACC);
    assign O_acc_valid = (state == S_OUT);
    assign O_acc       = acc;
    assign O_ovf       = ovf;
    assign O_cnt       = cnt;

endmodule

// File: tb/tb_adder_sum_acc.sv
// Testbench for adder_sum_acc: two instances (8-bit and 6-bit accumulator)
// share one directed stimulus stream and are compared every cycle against a
// frame-level arithmetic model, plus hand-computed literal expectations.
module tb_adder_sum_acc;

    localparam int LEN = 4;

    logic       clk;
    logic       rst;
    logic [4:0] sum;
    logic       sum_valid;
    logic       clr;
    logic       acc_ready;

    logic [7:0] acc8;
    logic [5:0] acc6;
    logic       ready8, ready6, valid8, valid6, ovf8, ovf6;
    logic [7:0] cnt8, cnt6;

    int passed;
    int total;
    bit chk_on;

    // model state per instance: 0 = 8-bit accumulator, 1 = 6-bit accumulator
    int m_acc [2];
    int m_ovf [2];
    int m_cnt [2];
    int m_hold[2];
    int m_max [2];

    adder_sum_acc #(
        .C_DATA_WIDTH(4),
        .C_ACC_LEN   (LEN),
        .C_ACC_WIDTH (8),
        .C_CNT_WIDTH (8)
    ) u_dut8 (
        .I_sys_clk  (clk),
        .I_rst      (rst),
        .I_sum      (sum),
        .I_sum_valid(sum_valid),
        .O_sum_ready(ready8),
        .I_clr      (clr),
        .O_acc      (acc8),
        .O_acc_valid(valid8),
        .I_acc_ready(acc_ready),
        .O_ovf      (ovf8),
        .O_cnt      (cnt8)
    );

    adder_sum_acc #(
        .C_DATA_WIDTH(4),
        .C_ACC_LEN   (LEN),
        .C_ACC_WIDTH (6),
        .C_CNT_WIDTH (8)
    ) u_dut6 (
        .I_sys_clk  (clk),
        .I_rst      (rst),
        .I_sum      (sum),
        .I_sum_valid(sum_valid),
        .O_sum_ready(ready6),
        .I_clr      (clr),
        .O_acc      (acc6),
        .O_acc_valid(valid6),
        .I_acc_ready(acc_ready),
        .O_ovf      (ovf6),
        .O_cnt      (cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Frame-level model: sums add with clamping, a frame closes after LEN
    // accepts and is held until consumed; clear and reset wipe everything.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || clr) begin
                m_acc[d]  = 0;
                m_ovf[d]  = 0;
                m_cnt[d]  = 0;
                m_hold[d] = 0;
            end else if (m_hold[d] != 0) begin
                if (acc_ready) begin
                    m_hold[d] = 0;
                    m_acc[d]  = 0;
                    m_ovf[d]  = 0;
                end
            end else if (sum_valid) begin
                int t;
                t = m_acc[d] + int'(sum);
                if (t > m_max[d]) begin
                    t = m_max[d];
                    m_ovf[d] = 1;
                end
                m_acc[d] = t;
                if (m_cnt[d] == LEN - 1) begin
                    m_cnt[d]  = 0;
                    m_hold[d] = 1;
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("acc8",   int'(acc8),   m_acc[0]);
            chk("ovf8",   int'(ovf8),   m_ovf[0]);
            chk("cnt8",   int'(cnt8),   m_cnt[0]);
            chk("valid8", int'(valid8), m_hold[0]);
            chk("ready8", int'(ready8), 1 - m_hold[0]);
            chk("acc6",   int'(acc6),   m_acc[1]);
            chk("ovf6",   int'(ovf6),   m_ovf[1]);
            chk("cnt6",   int'(cnt6),   m_cnt[1]);
            chk("valid6", int'(valid6), m_hold[1]);
            chk("ready6", int'(ready6), 1 - m_hold[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s);
        sum_valid = 1'b1;
        sum       = 5'(s);
        step();
        sum_valid = 1'b0;
    endtask

    initial begin
        int exp_cnt[4];
        passed    = 0;
        total     = 0;
        chk_on    = 1'b0;
        m_max[0]  = 255;
        m_max[1]  = 63;
        rst       = 1'b1;
        clr       = 1'b0;
        sum       = '0;
        sum_valid = 1'b0;
        acc_ready = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            m_acc[i % 2] = 0;
        end
        step();
        step();
        rst    = 1'b0;
        chk_on = 1'b1;

        // reset state
        chk("rst_acc",   int'(acc8),   0);
        chk("rst_valid", int'(valid8), 0);
        chk("rst_ready", int'(ready8), 1);
        chk("rst_cnt",   int'(cnt8),   0);
        chk("rst_ovf",   int'(ovf8),   0);

        // basic frame 3,5,7,9 with consumer ready
        acc_ready  = 1'b1;
        exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 0;
        send(3);
        chk("basic_cnt0", int'(cnt8), exp_cnt[0]);
        send(5);
        chk("basic_cnt1", int'(cnt8), exp_cnt[1]);
        send(7);
        chk("basic_cnt2", int'(cnt8), exp_cnt[2]);
        chk("basic_valid_early", int'(valid8), 0);
        send(9);
        chk("basic_cnt3",  int'(cnt8),   exp_cnt[3]);
        chk("basic_valid", int'(valid8), 1);
        chk("basic_acc",   int'(acc8),   24);
        chk("basic_ovf",   int'(ovf8),   0);
        chk("model_basic", m_acc[0],     24);
        step();
        chk("basic_done_valid", int'(valid8), 0);
        chk("basic_done_ready", int'(ready8), 1);
        chk("basic_done_acc",   int'(acc8),   0);

        // backpressure: held result with extra inputs ignored
        acc_ready = 1'b0;
        send(3); send(5); send(7); send(9);
        sum_valid = 1'b1;
        sum       = 5'd15;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", int'(valid8), 1);
            chk("bp_acc",   int'(acc8),   24);
            chk("bp_ready", int'(ready8), 0);
        end
        acc_ready = 1'b1;
        step();
        sum_valid = 1'b0;
        chk("bp_release_ready", int'(ready8), 1);
        chk("bp_release_acc",   int'(acc8),   0);
        chk("bp_release_cnt",   int'(cnt8),   0);

        // saturation: 6-bit instance clamps, 8-bit instance does not
        acc_ready = 1'b0;
        send(30); send(30); send(30); send(30);
        chk("sat_acc6",  int'(acc6), 63);
        chk("sat_ovf6",  int'(ovf6), 1);
        chk("sat_acc8",  int'(acc8), 120);
        chk("sat_ovf8",  int'(ovf8), 0);
        chk("model_sat", m_acc[1],   63);
        acc_ready = 1'b1;
        step();
        send(1); send(1); send(1); send(1);
        chk("post_sat_acc6", int'(acc6), 4);
        chk("post_sat_ovf6", int'(ovf6), 0);
        step();

        // all-ones sums: legal, no saturation at 8 bits
        send(31); send(31); send(31); send(31);
        chk("ones_acc8", int'(acc8), 124);
        chk("ones_ovf8", int'(ovf8), 0);
        chk("ones_acc6", int'(acc6), 63);
        step();

        // gapped input: valid on even beats only, count holds in the gaps
        acc_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sum_valid = (i % 2 == 0);
            sum       = 5'd10;
            step();
            if (i % 2 == 1) chk("gap_cnt_hold", int'(cnt8), (i + 1) / 2);
        end
        sum_valid = 1'b0;
        chk("gap_valid", int'(valid8), 1);
        chk("gap_acc",   int'(acc8),   40);
        acc_ready = 1'b1;
        step();

        // clear mid-frame drops the concurrent sum
        send(6); send(6);
        clr       = 1'b1;
        sum_valid = 1'b1;
        sum       = 5'd9;
        step();
        clr       = 1'b0;
        sum_valid = 1'b0;
        chk("clr_cnt", int'(cnt8), 0);
        chk("clr_acc", int'(acc8), 0);
        send(1); send(2); send(3); send(4);
        chk("clr_frame_acc",   int'(acc8),   10);
        chk("clr_frame_valid", int'(valid8), 1);
        step();

        // clear discards a held result
        acc_ready = 1'b0;
        send(8); send(8); send(8); send(8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_out_valid", int'(valid8), 0);
        chk("clr_out_acc",   int'(acc8),   0);

        // reset while holding a result
        send(3); send(5); send(7); send(9);
        chk("rst_out_hold", int'(acc8), 24);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", int'(valid8), 0);
        chk("rst_out_acc",   int'(acc8),   0);
        chk("rst_out_ready", int'(ready8), 1);
        acc_ready = 1'b1;
        send(2); send(2); send(2); send(2);
        chk("rst_next_acc", int'(acc8), 8);
        step();
        step();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
